// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: next-PC candidates, control events and committed fetch state
interface pc_sequencer_if;
   logic [15:0] nextPC_i;
   logic [15:0] Inc2_i;
   logic        Redirect_i;
   logic        PcStall_i;
   logic        Halt_i;
   logic        SIIC_i;
   logic        RTI_i;
   logic [15:0] PC_o;
   logic [15:0] EPC_o;
   logic        Halted_o;
   logic        InExc_o;
   logic        FlushIF_o;
   logic [15:0] FetchCount_o;
   modport master (
      output nextPC_i, Inc2_i, Redirect_i, PcStall_i, Halt_i, SIIC_i, RTI_i,
      input  PC_o, EPC_o, Halted_o, InExc_o, FlushIF_o, FetchCount_o
   );
   modport slave (
      input  nextPC_i, Inc2_i, Redirect_i, PcStall_i, Halt_i, SIIC_i, RTI_i,
      output PC_o, EPC_o, Halted_o, InExc_o, FlushIF_o, FetchCount_o
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC, EPC, halt/exception state and fetch counter
module pc_sequencer #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);
   typedef enum logic [1:0] {RUN, HANDLER, HALTED} state_t;
   state_t      state_q;
   logic [15:0] pc_q, epc_q, cnt_q;
   logic        halted_q, inexc_q, flush_q;
   // Control FSM: Halt > SIIC (RUN only) > PcStall > RTI (HANDLER only) > advance
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         epc_q    <= 16'h0000;
         cnt_q    <= 16'h0000;
         halted_q <= 1'b0;
         inexc_q  <= 1'b0;
         flush_q  <= 1'b0;
      end else if (state_q == HALTED) begin
         flush_q <= 1'b0;
      end else if (bus.Halt_i) begin
         state_q  <= HALTED;
         halted_q <= 1'b1;
         inexc_q  <= 1'b0;
         flush_q  <= 1'b0;
      end else if (bus.SIIC_i && state_q == RUN) begin
         state_q <= HANDLER;
         epc_q   <= bus.Inc2_i;
         pc_q    <= EXC_VECTOR;
         inexc_q <= 1'b1;
         flush_q <= 1'b1;
         cnt_q   <= cnt_q + 16'd1;
      end else if (bus.PcStall_i) begin
         flush_q <= 1'b0;
      end else if (bus.RTI_i && state_q == HANDLER) begin
         state_q <= RUN;
         pc_q    <= epc_q;
         inexc_q <= 1'b0;
         flush_q <= 1'b1;
         cnt_q   <= cnt_q + 16'd1;
      end else begin
         pc_q    <= bus.nextPC_i;
         flush_q <= bus.Redirect_i;
         cnt_q   <= cnt_q + 16'd1;
      end
   end
   assign bus.PC_o         = pc_q;
   assign bus.EPC_o        = epc_q;
   assign bus.Halted_o     = halted_q;
   assign bus.InExc_o      = inexc_q;
   assign bus.FlushIF_o    = flush_q;
   assign bus.FetchCount_o = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer
module tb_pc_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   pc_sequencer_if bus ();
   pc_sequencer #(.RESET_PC(16'h0000), .EXC_VECTOR(16'h0002)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct packed {
      logic [15:0] pc, epc, cnt;
      logic        h, x, f;
   } exp_t;
   exp_t        q[$];
   logic [15:0] m_pc, m_epc, m_cnt;
   logic        m_h, m_x, m_f;
   int          m_st;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic model(input logic r, input logic [15:0] np, inc, input logic rd, st, h, s, ri);
      if (r) begin
         m_st = 0; m_pc = 16'h0000; m_epc = 16'h0000; m_cnt = 16'h0000;
         m_h = 0; m_x = 0; m_f = 0;
      end else if (m_st == 2) m_f = 0;
      else if (h) begin
         m_st = 2; m_h = 1; m_x = 0; m_f = 0;
      end else if (s && m_st == 0) begin
         m_st = 1; m_epc = inc; m_pc = 16'h0002; m_x = 1; m_f = 1; m_cnt++;
      end else if (st) m_f = 0;
      else if (ri && m_st == 1) begin
         m_st = 0; m_pc = m_epc; m_x = 0; m_f = 1; m_cnt++;
      end else begin
         m_pc = np; m_f = rd; m_cnt++;
      end
   endtask
   task automatic step(input logic r, input logic [15:0] np, inc, input logic rd, st, h, s, ri);
      exp_t e;
      @(negedge clk);
      rst = r; bus.nextPC_i = np; bus.Inc2_i = inc; bus.Redirect_i = rd;
      bus.PcStall_i = st; bus.Halt_i = h; bus.SIIC_i = s; bus.RTI_i = ri;
      model(r, np, inc, rd, st, h, s, ri);
      q.push_back('{pc: m_pc, epc: m_epc, cnt: m_cnt, h: m_h, x: m_x, f: m_f});
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         chk("sb_empty", 16'd0, 16'd1);
      end else begin
         e = q.pop_front();
         chk("pc", bus.PC_o, e.pc);
         chk("epc", bus.EPC_o, e.epc);
         chk("cnt", bus.FetchCount_o, e.cnt);
         chk("halted", {15'd0, bus.Halted_o}, {15'd0, e.h});
         chk("inexc", {15'd0, bus.InExc_o}, {15'd0, e.x});
         chk("flush", {15'd0, bus.FlushIF_o}, {15'd0, e.f});
      end
   endtask
   task automatic adv(input logic [15:0] np, input logic rd);
      step(0, np, m_pc + 16'd2, rd, 0, 0, 0, 0);
   endtask
   initial begin
      bus.nextPC_i = 0; bus.Inc2_i = 0; bus.Redirect_i = 0; bus.PcStall_i = 0;
      bus.Halt_i = 0; bus.SIIC_i = 0; bus.RTI_i = 0;
      m_pc = 0; m_epc = 0; m_cnt = 0; m_h = 0; m_x = 0; m_f = 0; m_st = 0;
      step(1, 16'h1234, 16'h1236, 1, 1, 1, 1, 1);
      chk("rst_pc", bus.PC_o, 16'h0000);
      chk("rst_cnt", bus.FetchCount_o, 16'h0000);
      for (int i = 1; i <= 4; i++) begin
         adv(m_pc + 16'd2, 0);
         chk("run_pc", bus.PC_o, 16'(2 * i));
      end
      chk("run_cnt", bus.FetchCount_o, 16'd4);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      adv(16'h0002, 0);
      adv(16'h0004, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 16'h0006, 16'h0006, 0, 1, 0, 0, 0);
         chk("stall_pc", bus.PC_o, 16'h0004);
         chk("stall_cnt", bus.FetchCount_o, 16'd2);
      end
      adv(16'h0006, 0);
      chk("unstall_pc", bus.PC_o, 16'h0006);
      adv(16'h0010, 0);
      adv(16'h0040, 1);
      chk("br_pc", bus.PC_o, 16'h0040);
      chk("br_flush", {15'd0, bus.FlushIF_o}, 16'd1);
      adv(16'h0042, 0);
      chk("br_flush_off", {15'd0, bus.FlushIF_o}, 16'd0);
      adv(16'h0020, 1);
      step(0, 16'h0022, 16'h0022, 0, 1, 0, 1, 0);
      chk("exc_pc", bus.PC_o, 16'h0002);
      chk("exc_epc", bus.EPC_o, 16'h0022);
      chk("exc_inexc", {15'd0, bus.InExc_o}, 16'd1);
      step(0, 16'h0004, 16'h0099, 0, 0, 0, 1, 0);
      chk("nest_epc", bus.EPC_o, 16'h0022);
      step(0, 16'h0006, 16'h0006, 0, 1, 0, 0, 1);
      chk("rti_stall_pc", bus.PC_o, 16'h0004);
      step(0, 16'h0006, 16'h0006, 0, 0, 0, 0, 1);
      chk("rti_pc", bus.PC_o, 16'h0022);
      chk("rti_inexc", {15'd0, bus.InExc_o}, 16'd0);
      chk("rti_flush", {15'd0, bus.FlushIF_o}, 16'd1);
      step(0, 16'h0030, 16'h0024, 0, 0, 0, 0, 1);
      step(0, 16'h0032, 16'h0032, 0, 0, 1, 1, 0);
      chk("halt_pc", bus.PC_o, 16'h0030);
      chk("halt_flag", {15'd0, bus.Halted_o}, 16'd1);
      chk("halt_epc", bus.EPC_o, 16'h0022);
      for (int i = 0; i < 5; i++)
         step(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("halt_hold_pc", bus.PC_o, 16'h0030);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("halt_rst_pc", bus.PC_o, 16'h0000);
      chk("halt_rst_flag", {15'd0, bus.Halted_o}, 16'd0);
      for (int i = 0; i < 65536; i++) adv(m_pc + 16'd2, 0);
      chk("wrap_cnt", bus.FetchCount_o, 16'h0000);
      chk("wrap_pc", bus.PC_o, 16'h0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
